led_frame_sequencer: RTL and testbench

// - Upstream pixel source for the WS2812B serializer: walks the pixels of the current animation frame,

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_frame_sequencer_if.sv | 25 ++
 rtl/latch_timer.sv | 29 ++
 rtl/led_frame_sequencer.sv | 122 ++++++++++++
 tb/tb_led_frame_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared types and helpers for the WS2812B frame sequencer.
package led_pkg;

   localparam int unsigned WS_LATCH_US_MIN = 50;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      PRESENT,
      LATCH
   } seq_state_t;

   // WS2812B wire order is green, red, blue with green MSB first.
   function automatic logic [23:0] pack_grb(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
      return {g, r, b};
   endfunction

endpackage

// File: rtl/led_frame_sequencer_if.sv
// Colour memory read port plus pixel handshake towards the WS2812B serializer.
interface led_frame_sequencer_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned FIDX_W = 4
);
   logic [ADDR_W-1:0] read_address;
   logic [7:0]        red_data;
   logic [7:0]        green_data;
   logic [7:0]        blue_data;
   logic [23:0]       pixel_data;
   logic              pixel_valid;
   logic              pixel_ready;
   logic              frame_done;
   logic [FIDX_W-1:0] frame_index;

   modport master (
      output read_address, pixel_data, pixel_valid, frame_done, frame_index,
      input  red_data, green_data, blue_data, pixel_ready
   );

   modport slave (
      input  read_address, pixel_data, pixel_valid, frame_done, frame_index,
      output red_data, green_data, blue_data, pixel_ready
   );
endinterface

// File: rtl/latch_timer.sv
// Down-counter timing the line-idle gap; done pulses on the cycle the count reaches zero.
module latch_timer #(
   parameter int unsigned CYCLES = 720
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic done
);
   localparam int unsigned CNT_W = $clog2(CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            cnt  <= CNT_W'(CYCLES - 1);
            done <= (CYCLES == 1);
         end else if (cnt != '0) begin
            cnt  <= cnt - CNT_W'(1);
            done <= (cnt == CNT_W'(1));
         end
      end
   end
endmodule

// File: rtl/led_frame_sequencer.sv
// Walks the pixels of the current animation frame, packs GRB words for the serializer
// and inserts the latch gap between refreshes.
module led_frame_sequencer
   import led_pkg::*;
#(
   parameter int unsigned NUM_PIXELS = 64,
   parameter int unsigned NUM_FRAMES = 10,
   parameter int unsigned FRAME_HOLD = 30,
   parameter int unsigned CLK_HZ     = 12_000_000,
   parameter int unsigned LATCH_US   = 60
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   led_frame_sequencer_if.master bus
);
   localparam int unsigned ADDR_W    = (NUM_PIXELS * NUM_FRAMES > 1) ? $clog2(NUM_PIXELS * NUM_FRAMES) : 1;
   localparam int unsigned FIDX_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int unsigned PIX_W     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam int unsigned HOLD_W    = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
   localparam int unsigned LATCH_CYC = CLK_HZ / 1_000_000 * LATCH_US;

   seq_state_t        state;
   logic [PIX_W-1:0]  pixel;
   logic [HOLD_W-1:0] hold;
   logic [FIDX_W-1:0] frame_q;
   logic [ADDR_W-1:0] addr_q;
   logic [23:0]       data_q;
   logic              valid_q;
   logic              done_q;

   logic              xfer_c;
   logic              last_pixel_c;
   logic              last_hold_c;
   logic              latch_start_c;
   logic              latch_done;
   logic [FIDX_W-1:0] frame_next_c;

   assign xfer_c        = valid_q & bus.pixel_ready;
   assign last_pixel_c  = (pixel == PIX_W'(NUM_PIXELS - 1));
   assign last_hold_c   = (hold == HOLD_W'(FRAME_HOLD - 1));
   assign latch_start_c = (state == PRESENT) & xfer_c & last_pixel_c;

   // Frame the next refresh will display once the current gap ends.
   always_comb begin
      frame_next_c = frame_q;
      if (last_hold_c) begin
         if (frame_q == FIDX_W'(NUM_FRAMES - 1)) frame_next_c = '0;
         else                                    frame_next_c = frame_q + FIDX_W'(1);
      end
   end

   latch_timer #(.CYCLES(LATCH_CYC)) u_latch_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .start (latch_start_c),
      .done  (latch_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pixel   <= '0;
         hold    <= '0;
         frame_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (enable) begin
                  pixel  <= '0;
                  addr_q <= ADDR_W'(ADDR_W'(frame_q) * ADDR_W'(NUM_PIXELS));
                  state  <= FETCH;
               end
            end
            FETCH: state <= WAIT;
            WAIT: begin
               data_q  <= pack_grb(bus.red_data, bus.green_data, bus.blue_data);
               valid_q <= 1'b1;
               state   <= PRESENT;
            end
            PRESENT: begin
               if (xfer_c) begin
                  valid_q <= 1'b0;
                  if (last_pixel_c) begin
                     state <= LATCH;
                  end else begin
                     pixel  <= pixel + PIX_W'(1);
                     addr_q <= addr_q + ADDR_W'(1);
                     state  <= FETCH;
                  end
               end
            end
            LATCH: begin
               if (latch_done) begin
                  done_q  <= 1'b1;
                  pixel   <= '0;
                  hold    <= last_hold_c ? '0 : hold + HOLD_W'(1);
                  frame_q <= frame_next_c;
                  if (enable) begin
                     addr_q <= ADDR_W'(ADDR_W'(frame_next_c) * ADDR_W'(NUM_PIXELS));
                     state  <= FETCH;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.read_address = addr_q;
   assign bus.pixel_data   = data_q;
   assign bus.pixel_valid  = valid_q;
   assign bus.frame_done   = done_q;
   assign bus.frame_index  = frame_q;
endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer with a transfer scoreboard and a colour memory model.
module tb_led_frame_sequencer;
   localparam int unsigned NP   = 4;
   localparam int unsigned NF   = 3;
   localparam int unsigned FH   = 2;
   localparam int unsigned LUS  = 2;
   localparam int unsigned CLKF = 12_000_000;
   localparam int unsigned LCYC = CLKF / 1_000_000 * LUS;
   localparam int unsigned AW   = $clog2(NP * NF);
   localparam int unsigned FW   = $clog2(NF);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [23:0]   data;
      logic [FW-1:0] frame;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   xfers = 0;
   int   model_refresh = 0;
   exp_t sb[$];

   led_frame_sequencer_if #(.ADDR_W(AW), .FIDX_W(FW)) bus ();

   led_frame_sequencer #(
      .NUM_PIXELS (NP),
      .NUM_FRAMES (NF),
      .FRAME_HOLD (FH),
      .CLK_HZ     (CLKF),
      .LATCH_US   (LUS)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Colour memories: r=addr, g=addr+16, b=addr+32, one cycle read latency.
   always @(posedge clk) begin
      bus.red_data   <= 8'(bus.read_address);
      bus.green_data <= 8'(bus.read_address) + 8'd16;
      bus.blue_data  <= 8'(bus.read_address) + 8'd32;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] exp_data(input int unsigned a);
      logic [7:0] r;
      r = 8'(a);
      return {r + 8'd16, r, r + 8'd32};
   endfunction

   task automatic push_refresh();
      int unsigned f;
      exp_t e;
      f = (model_refresh / FH) % NF;
      for (int p = 0; p < NP; p++) begin
         e.addr  = AW'(f * NP + p);
         e.data  = exp_data(f * NP + p);
         e.frame = FW'(f);
         sb.push_back(e);
      end
      model_refresh++;
   endtask

   task automatic wait_xfers(input int n, input int budget);
      int k = 0;
      while (xfers < n && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("xfer_timeout", 32'(xfers >= n), 32'd1);
   endtask

   // A valid&ready pair seen at negedge transfers on the following posedge.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.pixel_valid && bus.pixel_ready) begin
         xfers++;
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("xfer_addr", 32'(bus.read_address), 32'(e.addr));
            chk("xfer_data", 32'(bus.pixel_data), 32'(e.data));
            chk("xfer_frame", 32'(bus.frame_index), 32'(e.frame));
         end
      end
   end

   initial begin
      logic [23:0]   hold_data;
      logic [AW-1:0] hold_addr;
      int k, fd, fd_at, found;

      bus.pixel_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(bus.pixel_valid), 32'd0);
      chk("rst_done", 32'(bus.frame_done), 32'd0);
      chk("rst_frame", 32'(bus.frame_index), 32'd0);
      chk("rst_addr", 32'(bus.read_address), 32'd0);
      chk("rst_data", 32'(bus.pixel_data), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_valid", 32'(bus.pixel_valid), 32'd0);

      // First pixel latency, then hold with ready low.
      push_refresh();
      enable = 1'b1;
      @(posedge clk); #1;
      chk("lat_e0_valid", 32'(bus.pixel_valid), 32'd0);
      chk("lat_e0_addr", 32'(bus.read_address), 32'd0);
      @(posedge clk); #1;
      chk("lat_e1_valid", 32'(bus.pixel_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_e2_valid", 32'(bus.pixel_valid), 32'd1);
      chk("first_data", 32'(bus.pixel_data), 32'h10_00_20);
      hold_data = bus.pixel_data;
      hold_addr = bus.read_address;
      repeat (10) begin
         @(negedge clk);
         chk("hold_data", 32'(bus.pixel_data), 32'(hold_data));
         chk("hold_addr", 32'(bus.read_address), 32'(hold_addr));
         chk("hold_valid", 32'(bus.pixel_valid), 32'd1);
      end
      chk("hold_no_xfer", 32'(xfers), 32'd0);
      @(posedge clk); #1 bus.pixel_ready = 1'b1;
      @(posedge clk); #1 bus.pixel_ready = 1'b0;
      chk("one_xfer_valid", 32'(bus.pixel_valid), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("one_xfer_count", 32'(xfers), 32'd1);
      bus.pixel_ready = 1'b1;

      // Latch gap measured from the last transfer edge to the next valid.
      wait_xfers(4, 100);
      push_refresh();
      @(posedge clk);
      k = 0; fd = 0; fd_at = 0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (bus.frame_done) begin fd++; fd_at = i; end
         if (bus.pixel_valid) begin k = i; break; end
      end
      chk("gap_len", 32'(k), 32'(LCYC + 2));
      chk("frame_done_width", 32'(fd), 32'd1);
      chk("frame_done_pos", 32'(fd_at), 32'(LCYC));

      // Refreshes 1..6 walk frames 0,1,1,2,2,0 and push refresh 7.
      for (int r = 1; r <= 6; r++) begin
         wait_xfers(4 * (r + 1), 200);
         push_refresh();
      end

      // Drop enable during pixel 1 of refresh 7.
      wait_xfers(29, 200);
      enable = 1'b0;
      wait_xfers(32, 200);
      found = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (bus.frame_done) begin found = 1; break; end
      end
      chk("stop_frame_done", 32'(found), 32'd1);
      repeat (40) @(posedge clk);
      #1;
      chk("stop_no_xfer", 32'(xfers), 32'd32);
      chk("stop_valid", 32'(bus.pixel_valid), 32'd0);
      chk("stop_frame", 32'(bus.frame_index), 32'((model_refresh / FH) % NF));
      push_refresh();
      enable = 1'b1;
      @(posedge clk); #1;
      chk("restart_addr", 32'(bus.read_address), 32'(((model_refresh - 1) / FH % NF) * NP));
      wait_xfers(36, 200);

      // Asynchronous reset while a pixel waits in PRESENT.
      @(posedge clk); #1 bus.pixel_ready = 1'b0;
      push_refresh();
      found = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (bus.pixel_valid) begin found = 1; break; end
      end
      chk("pre_rst_valid", 32'(found), 32'd1);
      chk("pre_rst_frame", 32'(bus.frame_index), 32'd1);
      @(negedge clk); #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(bus.pixel_valid), 32'd0);
      chk("async_rst_frame", 32'(bus.frame_index), 32'd0);
      chk("async_rst_addr", 32'(bus.read_address), 32'd0);
      sb.delete();
      model_refresh = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      push_refresh();
      @(posedge clk); #1 bus.pixel_ready = 1'b1;
      wait_xfers(40, 200);
      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
